// File: rtl/ula_muldiv.sv
// Iterative 32-bit unsigned multiply / divide unit (shift-add, restoring shift-subtract).
// Define ULA_MULDIV_REM_EN to enable the remainder operation (ULActl 5'b01001).
module ula_muldiv (
    input  logic        clock,
    input  logic        reset,
    input  logic        start,
    input  logic [4:0]  ULActl,
    input  logic [31:0] A,
    input  logic [31:0] B,
    output logic        busy,
    output logic        done,
    output logic [31:0] ULAout,
    output logic        zero,
    output logic        divzero
);

    localparam logic [1:0] IDLE = 2'd0;
    localparam logic [1:0] MUL  = 2'd1;
    localparam logic [1:0] DIV  = 2'd2;
    localparam logic [1:0] DONE = 2'd3;

    localparam logic [4:0] OP_MUL = 5'b00100;
    localparam logic [4:0] OP_DIV = 5'b00101;
`ifdef ULA_MULDIV_REM_EN
    localparam logic [4:0] OP_REM = 5'b01001;
`endif

    logic [1:0]  state;
    logic [5:0]  cnt;
    logic [31:0] acc;
    logic [31:0] opa;
    logic [31:0] opb;
    logic [31:0] rem;
    logic        is_rem_op;

    logic [31:0] acc_n;
    logic [32:0] rem_sh;
    logic        ge;
    logic [31:0] rem_n;
    logic [31:0] quo_n;

`ifdef ULA_MULDIV_REM_EN
    logic        rem_q;
    assign is_rem_op = (ULActl == OP_REM);
`else
    assign is_rem_op = 1'b0;
`endif

    // opa holds the multiplicand in MUL and the dividend/quotient in DIV
    always_comb begin
        acc_n  = opb[0] ? (acc + opa) : acc;
        rem_sh = {rem, opa[31]};
        ge     = (rem_sh >= {1'b0, opb});
        rem_n  = ge ? (rem_sh[31:0] - opb) : rem_sh[31:0];
        quo_n  = {opa[30:0], ge};
    end

    assign busy = (state != IDLE);
    assign done = (state == DONE);
    assign zero = (ULAout == 32'd0);

    always_ff @(posedge clock) begin
        if (!reset) begin
            state   <= IDLE;
            cnt     <= 6'd0;
            acc     <= 32'd0;
            opa     <= 32'd0;
            opb     <= 32'd0;
            rem     <= 32'd0;
            ULAout  <= 32'd0;
            divzero <= 1'b0;
`ifdef ULA_MULDIV_REM_EN
            rem_q   <= 1'b0;
`endif
        end else begin
            case (state)
                IDLE: begin
                    if (start) begin
                        divzero <= 1'b0;
                        opa     <= A;
                        opb     <= B;
                        acc     <= 32'd0;
                        rem     <= 32'd0;
                        cnt     <= 6'd0;
`ifdef ULA_MULDIV_REM_EN
                        rem_q   <= is_rem_op;
`endif
                        if (ULActl == OP_MUL) begin
                            cnt   <= 6'd32;
                            state <= MUL;
                        end else if (ULActl == OP_DIV || is_rem_op) begin
                            if (B == 32'd0) begin
                                ULAout  <= is_rem_op ? A : 32'hFFFF_FFFF;
                                divzero <= 1'b1;
                                state   <= DONE;
                            end else begin
                                cnt   <= 6'd32;
                                state <= DIV;
                            end
                        end else begin
                            ULAout <= 32'd0;
                            state  <= DONE;
                        end
                    end
                end
                MUL: begin
                    acc <= acc_n;
                    opa <= opa << 1;
                    opb <= opb >> 1;
                    cnt <= cnt - 6'd1;
                    if (cnt == 6'd1) begin
                        ULAout <= acc_n;
                        state  <= DONE;
                    end
                end
                DIV: begin
                    rem <= rem_n;
                    opa <= quo_n;
                    cnt <= cnt - 6'd1;
                    if (cnt == 6'd1) begin
`ifdef ULA_MULDIV_REM_EN
                        ULAout <= rem_q ? rem_n : quo_n;
`else
                        ULAout <= quo_n;
`endif
                        state  <= DONE;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_ula_muldiv.sv
// Scoreboard bench for ula_muldiv: stimulus pushes expectations, a monitor checks each done.
module tb_ula_muldiv;

    localparam logic [4:0] OP_MUL = 5'b00100;
    localparam logic [4:0] OP_DIV = 5'b00101;
    localparam logic [4:0] OP_REM = 5'b01001;

    logic        clock = 1'b0;
    logic        reset = 1'b0;
    logic        start = 1'b0;
    logic [4:0]  ULActl = 5'd0;
    logic [31:0] A = 32'd0;
    logic [31:0] B = 32'd0;
    logic        busy;
    logic        done;
    logic [31:0] ULAout;
    logic        zero;
    logic        divzero;

    ula_muldiv dut (
        .clock(clock), .reset(reset), .start(start), .ULActl(ULActl),
        .A(A), .B(B), .busy(busy), .done(done), .ULAout(ULAout),
        .zero(zero), .divzero(divzero)
    );

    always #5 clock = ~clock;

    typedef struct {
        string       name;
        logic [31:0] res;
        logic        dz;
        int          lat;
        int          t0;
    } exp_t;

    exp_t sb[$];
    int cyc = 0;
    int n_chk = 0;
    int n_err = 0;

    always @(posedge clock) cyc <= cyc + 1;

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] req);
        n_chk++;
        if (act !== req) begin
            n_err++;
            $display("FAIL %s: got %h, required %h", nm, act, req);
        end
    endtask

    // Monitor: every done pulse must match the oldest outstanding expectation
    always @(negedge clock) begin
        exp_t e;
        if (reset && done) begin
            if (sb.size() == 0) begin
                n_chk++;
                n_err++;
                $display("FAIL spurious_done: got done=1 at cycle %0d, required none", cyc);
            end else begin
                e = sb.pop_front();
                chk({e.name, "_res"}, ULAout, e.res);
                chk({e.name, "_zero"}, {31'd0, zero}, {31'd0, e.res == 32'd0});
                chk({e.name, "_divzero"}, {31'd0, divzero}, {31'd0, e.dz});
                chk({e.name, "_lat"}, cyc - e.t0, e.lat);
            end
        end
    end

    task automatic wait_idle();
        int n = 0;
        while (busy !== 1'b0 && n < 200) begin
            @(negedge clock);
            n++;
        end
        if (n >= 200) chk("idle_timeout", {31'd0, busy}, 32'd0);
    endtask

    task automatic issue(input logic [4:0] ctl, input logic [31:0] a, input logic [31:0] b,
                         input logic [31:0] res, input logic dz, input int lat,
                         input string nm);
        exp_t e;
        wait_idle();
        e.name = nm; e.res = res; e.dz = dz; e.lat = lat; e.t0 = cyc;
        sb.push_back(e);
        ULActl = ctl; A = a; B = b; start = 1'b1;
        @(negedge clock);
        start = 1'b0;
    endtask

    task automatic drain();
        int n = 0;
        while (sb.size() != 0 && n < 200) begin
            @(negedge clock);
            n++;
        end
        if (n >= 200) chk("drain_timeout", sb.size(), 0);
        @(negedge clock);
    endtask

    initial begin
        int bcnt;
        int chg;
        logic [31:0] held;

        // Reset held low with start high: reset wins
        start = 1'b1; ULActl = OP_MUL; A = 32'd3; B = 32'd3;
        repeat (3) @(negedge clock);
        chk("rst_busy", {31'd0, busy}, 32'd0);
        chk("rst_done", {31'd0, done}, 32'd0);
        chk("rst_ulaout", ULAout, 32'd0);
        chk("rst_zero", {31'd0, zero}, 32'd1);
        chk("rst_divzero", {31'd0, divzero}, 32'd0);
        start = 1'b0;
        reset = 1'b1;
        @(negedge clock);

        // mul 7*6 with busy profile and output stability
        issue(OP_MUL, 32'd7, 32'd6, 32'd42, 1'b0, 33, "mul_7x6");
        bcnt = 1; chg = 0; held = ULAout;
        while (!done && bcnt < 60) begin
            if (ULAout !== held) chg++;
            @(negedge clock);
            if (busy) bcnt++;
        end
        chk("mul_busy_cycles", bcnt, 33);
        chk("mul_out_stable", chg, 0);
        drain();

        issue(OP_MUL, 32'hFFFF_FFFF, 32'd2, 32'hFFFF_FFFE, 1'b0, 33, "mul_trunc");
        issue(OP_MUL, 32'd0, 32'd9, 32'd0, 1'b0, 33, "mul_zero");
        issue(OP_DIV, 32'd100, 32'd7, 32'd14, 1'b0, 33, "div_100_7");
`ifdef ULA_MULDIV_REM_EN
        issue(OP_REM, 32'd100, 32'd7, 32'd2, 1'b0, 33, "rem_100_7");
        issue(OP_REM, 32'hFFFF_FFFF, 32'd10, 32'd5, 1'b0, 33, "rem_max_10");
        issue(OP_REM, 32'd5, 32'd0, 32'd5, 1'b1, 1, "rem_by0");
`else
        issue(OP_REM, 32'd100, 32'd7, 32'd0, 1'b0, 1, "rem_100_7");
        issue(OP_REM, 32'hFFFF_FFFF, 32'd10, 32'd0, 1'b0, 1, "rem_max_10");
        issue(OP_REM, 32'd5, 32'd0, 32'd0, 1'b0, 1, "rem_by0");
`endif
        issue(OP_DIV, 32'd5, 32'd0, 32'hFFFF_FFFF, 1'b1, 1, "div_by0");
        issue(OP_DIV, 32'hFFFF_FFFF, 32'd1, 32'hFFFF_FFFF, 1'b0, 33, "div_max_1");
        issue(OP_DIV, 32'd7, 32'd9, 32'd0, 1'b0, 33, "div_7_9");
        issue(5'b00000, 32'd1, 32'd1, 32'd0, 1'b0, 1, "unsupported");
        drain();

        // start pulsed during DONE must be ignored
        issue(OP_DIV, 32'd8, 32'd0, 32'hFFFF_FFFF, 1'b1, 1, "div_by0_b");
        ULActl = 5'b00000; A = 32'd0; B = 32'd0; start = 1'b1;
        @(negedge clock);
        start = 1'b0;
        drain();

        // start at cycle 10 of a mul with new operands is ignored
        issue(OP_MUL, 32'd7, 32'd6, 32'd42, 1'b0, 33, "mul_ignore");
        repeat (9) @(negedge clock);
        ULActl = OP_MUL; A = 32'd3; B = 32'd3; start = 1'b1;
        @(negedge clock);
        start = 1'b0;
        drain();

        // reset at cycle 15 of a div aborts with no done pulse
        issue(OP_DIV, 32'd100, 32'd7, 32'd14, 1'b0, 33, "div_abort");
        repeat (14) @(negedge clock);
        void'(sb.pop_back());
        reset = 1'b0;
        @(negedge clock);
        chk("abort_busy", {31'd0, busy}, 32'd0);
        chk("abort_done", {31'd0, done}, 32'd0);
        chk("abort_ulaout", ULAout, 32'd0);
        chk("abort_zero", {31'd0, zero}, 32'd1);
        reset = 1'b1;
        repeat (40) @(negedge clock);
        issue(OP_DIV, 32'd9, 32'd3, 32'd3, 1'b0, 33, "div_9_3");
        drain();

        $display("== %0d vectors applied, %0d miscompares ==", n_chk, n_err);
        $finish;
    end

endmodule

// File: doc/ula_muldiv.md
ULA_MULDIV -- requirements
Module: ula_muldiv

Interface
- REQ-001 SHALL have input clock, 1 bit: sole clock; all state updates on rising edge.
- REQ-002 SHALL have input reset, 1 bit: synchronous, active-low reset, sampled on rising clock edge.
- REQ-003 SHALL have input start, 1 bit: operation request, sampled only in IDLE.
- REQ-004 SHALL have input ULActl, 5 bits: operation code; 5'b00100 mul, 5'b00101 div, 5'b01001 rem.
- REQ-005 SHALL have inputs A, B, 32 bits each: unsigned operands, captured on the edge that accepts start.
- REQ-006 SHALL have output busy, 1 bit: high in every state except IDLE.
- REQ-007 SHALL have output done, 1 bit: one-cycle completion pulse.
- REQ-008 SHALL have output ULAout, 32 bits: result, held stable from done until the next accepted start.
- REQ-009 SHALL have output zero, 1 bit: high when ULAout == 0.
- REQ-010 SHALL have output divzero, 1 bit: high with done when a div/rem had B == 0; held with ULAout.

Function
- REQ-011 SHALL implement states IDLE, MUL, DIV, DONE.
- REQ-012 SHALL accept start only in IDLE; start while busy is ignored and does not alter operands or state.
- REQ-013 SHALL, on accepted mul, enter MUL: iterative shift-add, one multiplier bit per cycle, 32 iterations, ULAout = low 32 bits of A*B (upper bits discarded).
- REQ-014 SHALL, on accepted div/rem with B != 0, enter DIV: restoring shift-subtract, one quotient bit per cycle, 32 iterations; div yields floor(A/B), rem yields A mod B.
- REQ-015 SHALL use a 6-bit iteration counter loaded with 32 on accept, decremented each MUL/DIV cycle; transition to DONE when counter reaches 0 after the 32nd iteration.
- REQ-016 SHALL assert done exactly in the cycle following the 33rd rising edge after the accepting edge for mul/div/rem with B != 0 (fixed latency 33).
- REQ-017 SHALL, for div/rem with B == 0, go IDLE->DONE on the accepting edge (latency 1): div ULAout = 32'hFFFFFFFF, rem ULAout = A, divzero = 1.
- REQ-018 SHALL, for any other ULActl value, go IDLE->DONE (latency 1) with ULAout = 0, divzero = 0.
- REQ-019 SHALL stay in DONE exactly one cycle, done high, then return to IDLE; start in DONE is ignored.
- REQ-020 SHALL clear divzero on every accepted start.
- REQ-021 SHALL allow back-to-back operations: start high in the first IDLE cycle after DONE is accepted.
- REQ-022 SHALL keep ULAout and zero unchanged during MUL/DIV (intermediate values internal only).

Reset
- REQ-023 SHALL, with reset low at a rising edge, force state IDLE, busy 0, done 0, ULAout 0, zero 1, divzero 0, counter 0, regardless of current state.
- REQ-024 SHALL abort an in-progress operation on reset with no done pulse; reset has priority over start.

Configuration
- REQ-025 SHALL use macro ULA_MULDIV_REM_EN: defined, rem (5'b01001) behaves per REQ-014/REQ-017.
- REQ-026 SHALL, without ULA_MULDIV_REM_EN, treat 5'b01001 as unsupported per REQ-018 (latency 1, ULAout 0, divzero 0); remainder output path not implemented.

Verification
- REQ-027 SHALL cover mul A=7, B=6 -> done 33 cycles after accept, ULAout=42, zero=0, busy high cycles 1..33.
- REQ-028 SHALL cover mul A=32'hFFFFFFFF, B=2 -> ULAout=32'hFFFFFFFE (truncation); mul A=0, B=9 -> ULAout=0, zero=1.
- REQ-029 SHALL cover div A=100, B=7 -> ULAout=14; rem A=100, B=7 -> ULAout=2 (macro defined), ULAout=0 after 1 cycle (macro undefined).
- REQ-030 SHALL cover div A=5, B=0 -> done after 1 cycle, ULAout=32'hFFFFFFFF, divzero=1; rem A=5, B=0 -> ULAout=5, divzero=1.
- REQ-031 SHALL cover start pulsed at cycle 10 of a mul with new operands -> ignored, original result delivered at cycle 33.
- REQ-032 SHALL cover reset low at cycle 15 of div -> next cycle busy=0, done never pulses, ULAout=0, then a new div 9/3 -> ULAout=3.
